// File: rtl/tm_sch_mem_bank_if.sv
// Bus bundle for tm_sch_mem_bank: shared PIO request/response plus
// per-channel application read/write ports, flattened per channel.
interface tm_sch_mem_bank_if #(
    parameter int NCH = 6,
    parameter int DW  = 32,
    parameter int AW  = 7,
    parameter int PW  = 32
);
    logic              clk_div;
    logic [PW-1:0]     reg_addr;
    logic [PW-1:0]     reg_din;
    logic              reg_rd;
    logic              reg_wr;
    logic [NCH-1:0]    reg_ms;
    logic [NCH-1:0]    app_rd;
    logic [NCH*AW-1:0] app_raddr;
    logic [NCH-1:0]    app_wr;
    logic [NCH*AW-1:0] app_waddr;
    logic [NCH*DW-1:0] app_wdata;
    logic              mem_ack;
    logic [PW-1:0]     mem_rdata;
    logic              mem_err;
    logic [NCH-1:0]    app_ack;
    logic [NCH*DW-1:0] app_rdata;
    logic              init_done;

    modport master (
        output clk_div, reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        output app_rd, app_raddr, app_wr, app_waddr, app_wdata,
        input  mem_ack, mem_rdata, mem_err, app_ack, app_rdata, init_done
    );

    modport slave (
        input  clk_div, reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        input  app_rd, app_raddr, app_wr, app_waddr, app_wdata,
        output mem_ack, mem_rdata, mem_err, app_ack, app_rdata, init_done
    );
endinterface

// File: rtl/tm_sch_mem_bank.sv
// Bank of NCH scheduler memories behind one shared PIO engine.
// Optional zero-init sweep after reset: define TM_SCH_MEM_INIT_EN.
module tm_sch_mem_bank #(
    parameter int             NCH     = 6,
    parameter int             DW      = 32,
    parameter int             AW      = 7,
    parameter int             PW      = 32,
    parameter logic [NCH-1:0] RW_MASK = 6'b101100,
    parameter int             PIO_TO  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    tm_sch_mem_bank_if.slave   bus
);
    localparam int         DEPTH   = 2 ** AW;
    localparam int         CW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [9:0] TO_LAST = 10'(PIO_TO - 1);

`ifdef TM_SCH_MEM_INIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACC, S_DONE, S_INIT
    } state_e;
    localparam state_e S_RST = S_INIT;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACC, S_DONE
    } state_e;
    localparam state_e S_RST = S_IDLE;
`endif

    logic [DW-1:0] mem [NCH][DEPTH];

    state_e        state_q, state_d;
    logic          op_wr_q, op_wr_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [9:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [PW-1:0] rdata_q, rdata_d;

    logic [NCH-1:0]    ack_q;
    logic [NCH*DW-1:0] ard_q;

    logic              init_busy;
    logic [AW-1:0]     init_wa;
    logic [NCH-1:0]    app_wr_eff;
    logic              req;
    logic              multi;
    logic [CW-1:0]     sel_ch;
    logic              port_free;
    logic              acc_go;
    logic              pio_we;
    logic [DW-1:0]     rd_val [NCH];
    logic              unused_bits;

`ifdef TM_SCH_MEM_INIT_EN
    logic [AW-1:0] init_a_q, init_a_d;
    assign init_busy = (state_q == S_INIT);
    assign init_wa   = init_a_q;
`else
    assign init_busy = 1'b0;
    assign init_wa   = '0;
`endif

    // Upper PIO address/data bits beyond AW/DW carry no meaning here.
    assign unused_bits = ^{bus.reg_addr, bus.reg_din};

    assign app_wr_eff = bus.app_wr & RW_MASK & {NCH{!init_busy}};
    assign req   = bus.clk_div & (bus.reg_rd | bus.reg_wr) & (|bus.reg_ms);
    assign multi = |(bus.reg_ms & (bus.reg_ms - 1'b1));

    always_comb begin
        sel_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.reg_ms[i]) sel_ch = CW'(i);
        end
    end

    // App traffic owns the port; PIO only touches it in an idle cycle.
    assign port_free = op_wr_q ? !app_wr_eff[ch_q] : !bus.app_rd[ch_q];
    assign acc_go    = (state_q == S_ACC) && port_free;
    assign pio_we    = acc_go && op_wr_q;

    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef TM_SCH_MEM_INIT_EN
        init_a_d = init_a_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_wr_d = bus.reg_wr;
                    ch_d    = sel_ch;
                    addr_d  = bus.reg_addr[AW-1:0];
                    data_d  = bus.reg_din[DW-1:0];
                    cnt_d   = '0;
                    err_d   = multi;
                    state_d = multi ? S_DONE : S_WAIT;
                end
            end
            S_WAIT, S_ACC: begin
                if (state_q == S_WAIT && port_free) begin
                    state_d = S_ACC;
                end else if (acc_go) begin
                    if (!op_wr_q) begin
                        rdata_d         = '0;
                        rdata_d[DW-1:0] = mem[ch_q][addr_q];
                    end
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
`ifdef TM_SCH_MEM_INIT_EN
            S_INIT: begin
                init_a_d = init_a_q + 1'b1;
                if (&init_a_q) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            op_wr_q <= 1'b0;
            ch_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef TM_SCH_MEM_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_a_q <= '0;
        else        init_a_q <= init_a_d;
    end
`endif

    // Same-cycle write to the read address is forwarded to the reader.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            rd_val[i] = mem[i][bus.app_raddr[i*AW +: AW]];
            if (pio_we && ch_q == CW'(i) &&
                addr_q == bus.app_raddr[i*AW +: AW])
                rd_val[i] = data_q;
            if (app_wr_eff[i] &&
                bus.app_waddr[i*AW +: AW] == bus.app_raddr[i*AW +: AW])
                rd_val[i] = bus.app_wdata[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (init_busy)
                mem[i][init_wa] <= '0;
            else if (app_wr_eff[i])
                mem[i][bus.app_waddr[i*AW +: AW]] <=
                    bus.app_wdata[i*DW +: DW];
            else if (pio_we && ch_q == CW'(i))
                mem[i][addr_q] <= data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= '0;
            ard_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ack_q[i] <= bus.app_rd[i] && !init_busy;
                if (bus.app_rd[i] && !init_busy)
                    ard_q[i*DW +: DW] <= rd_val[i];
            end
        end
    end

    assign bus.mem_ack   = (state_q == S_DONE);
    assign bus.mem_err   = (state_q == S_DONE) && err_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.app_ack   = ack_q;
    assign bus.app_rdata = ard_q;
    assign bus.init_done = !init_busy;
endmodule

// File: tb/tb_tm_sch_mem_bank.sv
// Randomized bench for tm_sch_mem_bank against a behavioural model.
// Init-sweep checks are active when TM_SCH_MEM_INIT_EN is defined.
module tb_tm_sch_mem_bank;
    localparam int             NCH     = 6;
    localparam int             DW      = 32;
    localparam int             AW      = 7;
    localparam int             PW      = 32;
    localparam int             PIO_TO  = 255;
    localparam logic [NCH-1:0] RW_MASK = 6'b101100;
    localparam int             MA      = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tm_sch_mem_bank_if #(.NCH(NCH), .DW(DW), .AW(AW), .PW(PW)) bus ();

    tm_sch_mem_bank #(
        .NCH(NCH), .DW(DW), .AW(AW), .PW(PW),
        .RW_MASK(RW_MASK), .PIO_TO(PIO_TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mdl [NCH][MA];
    bit            vld [NCH][MA];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clk_div   = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_din   = '0;
        bus.reg_rd    = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_ms    = '0;
        bus.app_rd    = '0;
        bus.app_raddr = '0;
        bus.app_wr    = '0;
        bus.app_waddr = '0;
        bus.app_wdata = '0;
    endtask

    task automatic pio(input bit rd, input bit wr, input logic [NCH-1:0] ms,
                       input int addr, input logic [DW-1:0] din,
                       output logic err, output logic [PW-1:0] rdat,
                       output int lat);
        bit seen = 1'b0;
        err  = 1'b0;
        rdat = '0;
        lat  = 0;
        bus.clk_div  = 1'b1;
        bus.reg_rd   = rd;
        bus.reg_wr   = wr;
        bus.reg_ms   = ms;
        bus.reg_addr = PW'(addr);
        bus.reg_din  = PW'(din);
        for (int k = 1; k <= PIO_TO + 20 && !seen; k++) begin
            tick();
            bus.clk_div = 1'b0;
            bus.reg_rd  = 1'b0;
            bus.reg_wr  = 1'b0;
            if (bus.mem_ack) begin
                seen = 1'b1;
                lat  = k;
                err  = bus.mem_err;
                rdat = bus.mem_rdata;
            end
        end
        check("pio_ack_seen", seen, 1);
        tick();
    endtask

    task automatic pio_wr(input int ch, input int a, input logic [DW-1:0] d);
        logic e; logic [PW-1:0] r; int l;
        pio(1'b0, 1'b1, NCH'(1) << ch, a, d, e, r, l);
        check("pio_wr_err", e, 0);
        check("pio_wr_lat", l, 3);
        mdl[ch][a] = d;
        vld[ch][a] = 1'b1;
    endtask

    task automatic pio_rd(input int ch, input int a);
        logic e; logic [PW-1:0] r; int l;
        pio(1'b1, 1'b0, NCH'(1) << ch, a, '0, e, r, l);
        check("pio_rd_err", e, 0);
        check("pio_rd_lat", l, 3);
        if (vld[ch][a]) check("pio_rd_data", r, PW'(mdl[ch][a]));
    endtask

    task automatic app_rd_chk(input int ch, input int a,
                              input logic [DW-1:0] exp);
        bus.app_rd[ch] = 1'b1;
        bus.app_raddr[ch*AW +: AW] = AW'(a);
        tick();
        check("app_ack", bus.app_ack[ch], 1);
        check("app_rdata", bus.app_rdata[ch*DW +: DW], exp);
        bus.app_rd[ch] = 1'b0;
        tick();
        check("app_ack_drop", bus.app_ack[ch], 0);
    endtask

`ifdef TM_SCH_MEM_INIT_EN
    task automatic wait_init(output int n);
        n = -1;
        for (int k = 1; k <= 2 ** AW + 20 && n < 0; k++) begin
            tick();
            if (bus.init_done) n = k;
        end
    endtask
`endif

    task automatic post_reset(input bit restart);
`ifdef TM_SCH_MEM_INIT_EN
        int n;
        bit bad = 1'b0;
        bus.app_rd = '1;
        bus.clk_div = 1'b1;
        bus.reg_wr = 1'b1;
        bus.reg_ms = 6'b000001;
        tick();
        bus.clk_div = 1'b0;
        bus.reg_wr = 1'b0;
        if (restart) begin
            for (int k = 0; k < 40; k++) begin
                if (bus.app_ack != 0 || bus.mem_ack) bad = 1'b1;
                tick();
            end
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        n = 0;
        for (int k = 1; k <= 2 ** AW + 20 && !bus.init_done; k++) begin
            if (bus.app_ack != 0 || bus.mem_ack) bad = 1'b1;
            tick();
            n = k;
        end
        check("init_gate", bad, 0);
        check("init_cycles", n, restart ? 2 ** AW : 2 ** AW - 1);
        bus.app_rd = '0;
        tick();
        check("init_no_pio_ack", bus.mem_ack, 0);
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < MA; a++) begin
                mdl[c][a] = '0;
                vld[c][a] = 1'b1;
            end
        app_rd_chk(4, 2 ** AW - 1, '0);
        app_rd_chk(0, 5, '0);
`else
        if (restart) tick();
`endif
    endtask

    logic [NCH-1:0] nck;
    bit             kn [NCH];
    logic [DW-1:0]  ex [NCH];

    initial begin
        logic e; logic [PW-1:0] r; int l; logic [PW-1:0] held;
        bit pend, pwr, pkn, cool, any;
        int pch, pa, pcnt;
        logic [DW-1:0] pdat;

        idle_inputs();
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < MA; a++) vld[c][a] = 1'b0;

        bus.app_rd = '1;
        tick();
        tick();
        check("rst_mem_ack", bus.mem_ack, 0);
        check("rst_mem_err", bus.mem_err, 0);
        check("rst_mem_rdata", bus.mem_rdata, 0);
        check("rst_app_ack", bus.app_ack, 0);
        check("rst_app_rdata", bus.app_rdata != 0, 0);
`ifdef TM_SCH_MEM_INIT_EN
        check("rst_init_done", bus.init_done, 0);
`else
        check("rst_init_done", bus.init_done, 1);
`endif
        bus.app_rd = '0;
        rst_n = 1'b1;
        post_reset(1'b1);

        pio_wr(0, 5, 32'h1234);
        app_rd_chk(0, 5, 32'h1234);

        bus.app_wr[2] = 1'b1;
        bus.app_waddr[2*AW +: AW] = AW'(9);
        bus.app_wdata[2*DW +: DW] = 32'hABCD;
        app_rd_chk(2, 9, 32'hABCD);
        bus.app_wr[2] = 1'b0;
        mdl[2][9] = 32'hABCD;
        vld[2][9] = 1'b1;
        pio_rd(2, 9);

        held = bus.mem_rdata;
        bus.app_rd[3] = 1'b1;
        pio(1'b1, 1'b0, 6'b001000, 7, '0, e, r, l);
        check("to_err", e, 1);
        check("to_lat", l, PIO_TO + 1);
        check("to_rdata_held", r, held);
        check("to_app_ack", bus.app_ack[3], 1);
        bus.app_rd[3] = 1'b0;

        pio_wr(1, 5, 32'h5555);
        pio(1'b0, 1'b1, 6'b000011, 5, 32'hDEAD, e, r, l);
        check("ms_err", e, 1);
        check("ms_lat", l, 1);
        pio_rd(0, 5);
        pio_rd(1, 5);

        bus.app_wr[1] = 1'b1;
        bus.app_waddr[1*AW +: AW] = AW'(5);
        bus.app_wdata[1*DW +: DW] = 32'h9999;
        tick();
        bus.app_wr[1] = 1'b0;
        pio_rd(1, 5);

        pio(1'b1, 1'b1, 6'b100000, 3, 32'h77, e, r, l);
        check("rdwr_err", e, 0);
        mdl[5][3] = 32'h77;
        vld[5][3] = 1'b1;
        pio_rd(5, 3);

        // Reset while PIO is stuck in WAIT must drop it silently.
        bus.app_rd[3] = 1'b1;
        bus.clk_div = 1'b1;
        bus.reg_rd = 1'b1;
        bus.reg_ms = 6'b001000;
        tick();
        bus.clk_div = 1'b0;
        bus.reg_rd = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_app_ack", bus.app_ack, 0);
        check("mid_rst_mem_ack", bus.mem_ack, 0);
        bus.app_rd[3] = 1'b0;
        rst_n = 1'b1;
        post_reset(1'b0);
        any = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.mem_ack) any = 1'b1;
        end
        check("mid_rst_no_ack", any, 0);
        pio_rd(0, 5);

        pend = 1'b0;
        cool = 1'b0;
        pkn = 1'b0;
        pwr = 1'b0;
        pch = 0; pa = 0; pcnt = 0; pdat = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.clk_div = 1'b0;
            bus.reg_rd  = 1'b0;
            bus.reg_wr  = 1'b0;
            if (!pend && !cool && $urandom_range(5) == 0) begin
                pch  = $urandom_range(NCH - 1);
                pa   = $urandom_range(MA - 1);
                pwr  = $urandom_range(1) == 1;
                pdat = $urandom;
                bus.clk_div  = 1'b1;
                bus.reg_rd   = !pwr;
                bus.reg_wr   = pwr;
                bus.reg_ms   = NCH'(1) << pch;
                bus.reg_addr = PW'(pa) | (PW'($urandom) << AW);
                bus.reg_din  = PW'(pdat);
                pkn = vld[pch][pa];
                if (pwr) vld[pch][pa] = 1'b0;
                pend = 1'b1;
                pcnt = 0;
            end else if ($urandom_range(7) == 0) begin
                bus.clk_div = pend;
                bus.reg_wr  = 1'b1;
                bus.reg_ms  = NCH'(1) << $urandom_range(NCH - 1);
                bus.reg_addr = PW'($urandom_range(MA - 1));
                bus.reg_din = $urandom;
            end
            if (pend && !pwr) pdat = mdl[pch][pa];
            for (int i = 0; i < NCH; i++) begin
                bit rd, wr;
                int ra, wa;
                logic [DW-1:0] wd;
                rd = $urandom_range(2) == 0;
                wr = $urandom_range(2) == 0;
                ra = $urandom_range(MA - 1);
                wa = $urandom_range(1) ? ra : $urandom_range(MA - 1);
                wd = $urandom;
                if (pend && i == pch) begin
                    wr = 1'b0;
                    if ($urandom_range(3) != 0) rd = 1'b0;
                end
                bus.app_rd[i] = rd;
                bus.app_wr[i] = wr;
                bus.app_raddr[i*AW +: AW] = AW'(ra);
                bus.app_waddr[i*AW +: AW] = AW'(wa);
                bus.app_wdata[i*DW +: DW] = wd;
                nck[i] = rd;
                if (RW_MASK[i] && wr && wa == ra) begin
                    kn[i] = 1'b1;
                    ex[i] = wd;
                end else begin
                    kn[i] = vld[i][ra];
                    ex[i] = mdl[i][ra];
                end
                if (RW_MASK[i] && wr) begin
                    mdl[i][wa] = wd;
                    vld[i][wa] = 1'b1;
                end
            end
            tick();
            for (int i = 0; i < NCH; i++) begin
                check("rnd_app_ack", bus.app_ack[i], nck[i]);
                if (nck[i] && kn[i])
                    check("rnd_app_rdata", bus.app_rdata[i*DW +: DW], ex[i]);
            end
            cool = 1'b0;
            if (pend) begin
                pcnt++;
                if (bus.mem_ack) begin
                    check("rnd_pio_err", bus.mem_err, 0);
                    if (!pwr && pkn)
                        check("rnd_pio_rdata", bus.mem_rdata, PW'(pdat));
                    if (pwr) begin
                        mdl[pch][pa] = pdat;
                        vld[pch][pa] = 1'b1;
                    end
                    pend = 1'b0;
                    cool = 1'b1;
                end else if (pcnt > 200) begin
                    check("rnd_pio_ack_bound", bus.mem_ack, 1);
                    pend = 1'b0;
                    cool = 1'b1;
                end
            end else begin
                check("rnd_no_ack", bus.mem_ack, 0);
            end
        end
        idle_inputs();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
